// File: rtl/overlay_pkg.sv
// Shared constants for the overlay configuration master.
// Register map, status/control bits, fault codes and state encodings.
package overlay_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_WIDTH  = 8'h04;
  localparam logic [7:0] REG_HEIGHT = 8'h08;
  localparam logic [7:0] REG_HLOC   = 8'h14;
  localparam logic [7:0] REG_VLOC   = 8'h18;
  localparam logic [7:0] REG_HBEGIN = 8'h24;
  localparam logic [7:0] REG_HEND   = 8'h28;
  localparam logic [7:0] REG_VBEGIN = 8'h2C;
  localparam logic [7:0] REG_VEND   = 8'h30;

  localparam int RUN_BIT        = 0;
  localparam int DONE_BIT       = 2;
  localparam int LOGO_VALID_BIT = 3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BRESP   = 2'd1;
  localparam logic [1:0] ERR_RRESP   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [2:0] LAST_WR = 3'd6;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, POLL_WAIT,
    RD_REQ, RD_RESP, FINISH, ERR
  } state_t;

  typedef enum logic [2:0] {
    XS_IDLE, XS_WR, XS_B, XS_AR, XS_R
  } xstate_t;

  function automatic logic [7:0] wr_addr(input logic [2:0] step);
    logic [7:0] a;
    unique case (step)
      3'd0:    a = REG_WIDTH;
      3'd1:    a = REG_HEIGHT;
      3'd2:    a = REG_HBEGIN;
      3'd3:    a = REG_HEND;
      3'd4:    a = REG_VBEGIN;
      3'd5:    a = REG_VEND;
      default: a = REG_CTRL;
    endcase
    return a;
  endfunction

  function automatic logic [7:0] rd_addr(input logic [2:0] step);
    logic [7:0] a;
    unique case (step)
      3'd1:    a = REG_HLOC;
      3'd2:    a = REG_VLOC;
      default: a = REG_CTRL;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/overlay_cfg_master_if.sv
// AXI4-Lite bus bundle between the config master and the overlay core.
// master drives requests, slave drives ready/response.
interface overlay_cfg_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/overlay_axil_xact.sv
// Single-beat AXI4-Lite read/write engine.
// Accepts req only when idle; ack pulses once the response is taken.
module overlay_axil_xact #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            resp,
  overlay_cfg_master_if.master  m_axi
);
  import overlay_pkg::*;

  xstate_t xs;

  assign m_axi.wstrb  = '1;
  assign m_axi.awprot = 3'd0;
  assign m_axi.arprot = 3'd0;

  // One transaction at a time; each VALID drops on its own handshake
  always_ff @(posedge S_AXI_ACLK) begin
    if (reset) begin
      xs            <= XS_IDLE;
      m_axi.awaddr  <= '0;
      m_axi.awvalid <= 1'b0;
      m_axi.wdata   <= '0;
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
      m_axi.araddr  <= '0;
      m_axi.arvalid <= 1'b0;
      m_axi.rready  <= 1'b0;
      ack           <= 1'b0;
      rdata         <= '0;
      resp          <= 2'b00;
    end else begin
      ack <= 1'b0;
      unique case (xs)
        XS_IDLE: if (req) begin
          if (we) begin
            m_axi.awaddr  <= addr;
            m_axi.wdata   <= wdata;
            m_axi.awvalid <= 1'b1;
            m_axi.wvalid  <= 1'b1;
            xs            <= XS_WR;
          end else begin
            m_axi.araddr  <= addr;
            m_axi.arvalid <= 1'b1;
            xs            <= XS_AR;
          end
        end
        XS_WR: begin
          if (m_axi.awready) m_axi.awvalid <= 1'b0;
          if (m_axi.wready)  m_axi.wvalid  <= 1'b0;
          if ((!m_axi.awvalid || m_axi.awready) &&
              (!m_axi.wvalid  || m_axi.wready)) begin
            m_axi.bready <= 1'b1;
            xs           <= XS_B;
          end
        end
        XS_B: if (m_axi.bvalid) begin
          m_axi.bready <= 1'b0;
          resp         <= m_axi.bresp;
          ack          <= 1'b1;
          xs           <= XS_IDLE;
        end
        XS_AR: if (m_axi.arready) begin
          m_axi.arvalid <= 1'b0;
          m_axi.rready  <= 1'b1;
          xs            <= XS_R;
        end
        XS_R: if (m_axi.rvalid) begin
          m_axi.rready <= 1'b0;
          rdata        <= m_axi.rdata;
          resp         <= m_axi.rresp;
          ack          <= 1'b1;
          xs           <= XS_IDLE;
        end
        default: xs <= XS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/overlay_cfg_master.sv
// Overlay core configuration master.
// Programs frame/window registers, polls for done, reads back location.
module overlay_cfg_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int POLL_GAP   = 16,
  parameter int MAX_POLLS  = 1024
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] cfg_width,
  input  logic [DATA_WIDTH-1:0] cfg_height,
  input  logic [DATA_WIDTH-1:0] cfg_hbegin,
  input  logic [DATA_WIDTH-1:0] cfg_hend,
  input  logic [DATA_WIDTH-1:0] cfg_vbegin,
  input  logic [DATA_WIDTH-1:0] cfg_vend,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [DATA_WIDTH-1:0] frame_hloc,
  output logic [DATA_WIDTH-1:0] frame_vloc,
  overlay_cfg_master_if.master  m_axi
);
  import overlay_pkg::*;

  localparam int PW = $clog2(MAX_POLLS + 1);
  localparam int GW = $clog2(POLL_GAP + 1) + 1;
  localparam logic [DATA_WIDTH-1:0] CTRL_WORD =
    DATA_WIDTH'((1 << RUN_BIT) | (1 << LOGO_VALID_BIT));

  state_t                state;
  logic [2:0]            step;
  logic [PW-1:0]         polls;
  logic [GW-1:0]         gap;
  logic [DATA_WIDTH-1:0] cfg_q [7];

  logic                  req;
  logic                  we;
  logic                  ack;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] xrdata;
  logic [1:0]            resp;

  overlay_axil_xact #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_xact (
    .S_AXI_ACLK (S_AXI_ACLK),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .ack        (ack),
    .rdata      (xrdata),
    .resp       (resp),
    .m_axi      (m_axi)
  );

  // Sequencer: write the register list, poll status, read location
  always_ff @(posedge S_AXI_ACLK) begin
    if (reset) begin
      state      <= IDLE;
      step       <= '0;
      polls      <= '0;
      gap        <= '0;
      req        <= 1'b0;
      we         <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
      frame_hloc <= '0;
      frame_vloc <= '0;
      for (int i = 0; i < 7; i++) cfg_q[i] <= '0;
    end else begin
      done <= 1'b0;
      req  <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          cfg_q[0] <= cfg_width;
          cfg_q[1] <= cfg_height;
          cfg_q[2] <= cfg_hbegin;
          cfg_q[3] <= cfg_hend;
          cfg_q[4] <= cfg_vbegin;
          cfg_q[5] <= cfg_vend;
          cfg_q[6] <= CTRL_WORD;
          error    <= 1'b0;
          err_code <= ERR_NONE;
          busy     <= 1'b1;
          step     <= '0;
          polls    <= '0;
          state    <= WR_REQ;
        end
        WR_REQ: begin
          req   <= 1'b1;
          we    <= 1'b1;
          addr  <= ADDR_WIDTH'(wr_addr(step));
          wdata <= cfg_q[step];
          state <= WR_RESP;
        end
        WR_RESP: if (ack) begin
          if (resp != 2'b00) begin
            err_code <= ERR_BRESP;
            state    <= ERR;
          end else if (step == LAST_WR) begin
            step  <= '0;
            gap   <= '0;
            state <= POLL_WAIT;
          end else begin
            step  <= step + 3'd1;
            state <= WR_REQ;
          end
        end
        POLL_WAIT: begin
          if (32'(gap) + 1 >= POLL_GAP) state <= RD_REQ;
          else gap <= gap + 1'b1;
        end
        RD_REQ: begin
          req   <= 1'b1;
          we    <= 1'b0;
          addr  <= ADDR_WIDTH'(rd_addr(step));
          state <= RD_RESP;
        end
        RD_RESP: if (ack) begin
          if (resp != 2'b00) begin
            err_code <= ERR_RRESP;
            state    <= ERR;
          end else if (step == 3'd0) begin
            if (xrdata[DONE_BIT]) begin
              step  <= 3'd1;
              state <= RD_REQ;
            end else begin
              polls <= polls + 1'b1;
              if (32'(polls) + 1 >= MAX_POLLS) begin
                err_code <= ERR_TIMEOUT;
                state    <= ERR;
              end else begin
                gap   <= '0;
                state <= POLL_WAIT;
              end
            end
          end else if (step == 3'd1) begin
            frame_hloc <= xrdata;
            step       <= 3'd2;
            state      <= RD_REQ;
          end else begin
            frame_vloc <= xrdata;
            state      <= FINISH;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          error <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
